// File: rtl/mips_lsu_bus.sv
// Load/store unit bridging the MIPS core to an Avalon-style bus: one request
// at a time, lane steering, byte enables, load extension, misalign/timeout errors.
module mips_lsu_bus #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic                  waitrequest,
  input  logic [DATA_W-1:0]     readdata,
  output logic [1:0]            dbg_state
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic [OFS_W-1:0]    ofs_q, ofs_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [OFS_W-1:0]    req_ofs;
  int                  n_bytes;
  int                  n_bits;
  logic                illegal;
  logic [DATA_W-1:0]   lane_mask;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   ext;
  logic                sign_bit;

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 2'b00;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    ofs_d    = ofs_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;

    req_ofs = req_addr[OFS_W-1:0];
    n_bytes = 1 << req_size;
    illegal = (int'(req_size) > OFS_W) || ((int'(req_ofs) & (n_bytes - 1)) != 0);

    // Byte lanes for a new request; used only when it is accepted as legal.
    lane_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      lane_mask[8*b +: 8] = {8{(b >= int'(req_ofs)) && (b < int'(req_ofs) + n_bytes)}};
    end

    shifted  = readdata >> {ofs_q, 3'b000};
    n_bits   = 8 << size_q;
    sign_bit = shifted[IDX_W'(n_bits - 1)];
    ext      = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ext[i] = (i < n_bits) ? shifted[i] : (sgn_q & sign_bit);
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ofs_d   = req_ofs;
          size_d  = req_size;
          sgn_d   = req_signed;
          ready_d = 1'b0;
          if (illegal) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            err_d    = 2'b01;
          end else begin
            state_d = S_BUS;
            addr_d  = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            for (int b = 0; b < BYTES; b++) be_d[b] = lane_mask[8*b];
            wdata_d = (req_wdata << {req_ofs, 3'b000}) & lane_mask;
            rd_d    = !req_write;
            wr_d    = req_write;
            cnt_d   = '0;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = rd_q ? ext : '0;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          be_d     = '0;
          wdata_d  = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          err_d    = 2'b10;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          be_d     = '0;
          wdata_d  = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 2'b00;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      ofs_q    <= '0;
      size_q   <= 2'b00;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ofs_q    <= ofs_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign address    = addr_q;
  assign read       = rd_q;
  assign write      = wr_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_lsu_bus.sv
// Bench for mips_lsu_bus (DATA_W=32, TIMEOUT_CYCLES=4): cycle-level expectations
// derived from access rules and latency, checked every cycle, plus literal vectors.
module tb_mips_lsu_bus;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  dbg_state;

  mips_lsu_bus #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected per-cycle outputs, written by the driver, compared on negedge
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_rv, exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wd, exp_rdata;
  logic [3:0]  exp_be;
  logic [1:0]  exp_err;

  int          strobe_cnt;
  logic [31:0] first_addr, first_wd, last_rdata;
  logic [3:0]  first_be;
  logic [1:0]  last_err;

  // reference model: plain arithmetic on the access rules
  function automatic logic m_illegal(input int sz, input int ofs);
    return (sz > 2) || ((ofs % (1 << sz)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input int ofs, input int n);
    logic [31:0] v;
    v = ((32'd1 << n) - 32'd1) << ofs;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] wd, input int ofs, input int n);
    logic [31:0] mask;
    mask = (n == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * n)) - 32'd1) << (8 * ofs));
    return (wd << (8 * ofs)) & mask;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdv, input int ofs, input int n, input logic sg);
    logic [31:0] v, mask;
    v = rdv >> (8 * ofs);
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (sg && ((v >> (8 * n - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    end
    return v;
  endfunction

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, exp_ready);
      check("resp_valid", resp_valid, exp_rv);
      check("read", read, exp_rd);
      check("write", write, exp_wr);
      if (exp_rd || exp_wr) begin
        check("address", address, exp_addr);
        check("byteenable", byteenable, exp_be);
        check("writedata", writedata, exp_wd);
      end
      if (exp_rv) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", resp_err, exp_err);
      end
    end
    if (read || write) begin
      if (strobe_cnt == 0) begin
        first_addr = address;
        first_be   = byteenable;
        first_wd   = writedata;
      end
      strobe_cnt++;
    end
    if (resp_valid) begin
      last_rdata = resp_rdata;
      last_err   = resp_err;
    end
  end

  task automatic set_idle_exp();
    exp_ready = 1'b1; exp_rv = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
  endtask

  // driver: called #1 after a rising edge with the unit idle; returns the same way
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdv, input int k);
    int n, ofs, strobes;
    logic tmo;
    n = 1 << sz;
    ofs = int'(a[1:0]);
    strobe_cnt = 0;
    last_rdata = 32'hDEAD_DEAD;
    last_err   = 2'b11;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    set_idle_exp();
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
    req_signed = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    if (m_illegal(int'(sz), ofs)) begin
      exp_ready = 1'b0; exp_rv = 1'b1; exp_rdata = 32'h0; exp_err = 2'b01;
      @(posedge clk); #1;
      set_idle_exp();
      return;
    end
    tmo = (k >= T);
    strobes = tmo ? T : k + 1;
    exp_addr = {a[31:2], 2'b00};
    exp_be   = m_be(ofs, n);
    exp_wd   = m_wd(wd, ofs, n);
    for (int c = 1; c <= strobes; c++) begin
      exp_ready = 1'b0; exp_rv = 1'b0; exp_rd = !w; exp_wr = w;
      waitrequest = tmo || (c <= k);
      readdata = waitrequest ? $urandom : rdv;
      @(posedge clk); #1;
    end
    waitrequest = 1'b0;
    readdata = $urandom;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_rv = 1'b1;
    exp_rdata = (tmo || w) ? 32'h0 : m_load(rdv, ofs, n, sg);
    exp_err = tmo ? 2'b10 : 2'b00;
    @(posedge clk); #1;
    set_idle_exp();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
    strobe_cnt = 0;
    set_idle_exp();
    exp_addr = '0; exp_wd = '0; exp_be = '0; exp_rdata = '0; exp_err = '0;

    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", resp_err, 2'b00);
    check("rst_address", address, 32'h0);
    check("rst_read", read, 1'b0);
    check("rst_write", write, 1'b0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_byteenable", byteenable, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // pin the model against hand-computed values
    check("model_load_sb", m_load(32'h80AABBCC, 3, 1, 1'b1), 32'hFFFFFF80);
    check("model_load_uh", m_load(32'h1234F00D, 0, 2, 1'b0), 32'h0000F00D);
    check("model_wd_half", m_wd(32'h0000BEEF, 2, 2), 32'hBEEF0000);
    check("model_be_half", m_be(2, 2), 4'b1100);

    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80AABBCC, 0);
    check("tp1_addr", first_addr, 32'h100);
    check("tp1_be", first_be, 4'b1000);
    check("tp1_strobes", strobe_cnt, 1);
    check("tp1_rdata", last_rdata, 32'hFFFFFF80);
    check("tp1_err", last_err, 2'b00);

    run_txn(1'b0, 2'd1, 1'b0, 32'h000, 32'h0, 32'h1234F00D, 0);
    check("tp2_be", first_be, 4'b0011);
    check("tp2_rdata", last_rdata, 32'h0000F00D);

    run_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 32'h0, 3);
    check("tp3_wd", first_wd, 32'hBEEF0000);
    check("tp3_be", first_be, 4'b1100);
    check("tp3_strobes", strobe_cnt, 4);
    check("tp3_rdata", last_rdata, 32'h0);

    run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0);
    check("tp4_strobes", strobe_cnt, 0);
    check("tp4_err", last_err, 2'b01);
    run_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    check("tp4_dword_err", last_err, 2'b01);

    run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'hCAFE0001, 10);
    check("tp5_tmo_strobes", strobe_cnt, 4);
    check("tp5_tmo_err", last_err, 2'b10);
    check("tp5_tmo_rdata", last_rdata, 32'h0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'hCAFE0001, 3);
    check("tp5_late_err", last_err, 2'b00);
    check("tp5_late_rdata", last_rdata, 32'hCAFE0001);

    // reset pulsed during a stalled store
    chk_en = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h204; req_wdata = 32'h11223344; waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_write_pre", write, 1'b1);
    strobe_cnt = 0;
    last_err = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_write", write, 1'b0);
    check("rst_mid_be", byteenable, 4'h0);
    check("rst_mid_ready", req_ready, 1'b1);
    check("rst_mid_rv", resp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    waitrequest = 1'b0;
    @(negedge clk);
    check("rst_mid_no_resp", resp_valid, 1'b0);
    @(posedge clk); #1;
    check("rst_mid_no_resp_seen", last_err, 2'b11);
    set_idle_exp();
    chk_en = 1'b1;
    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h5A5AA5A5, 0);
    check("rst_after_rdata", last_rdata, 32'h5A5AA5A5);
    check("rst_after_err", last_err, 2'b00);

    // randomized traffic, mostly back to back
    for (int t = 0; t < 80; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              $urandom, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_lsu_bus.md
# mips_lsu_bus

Parametrised load/store unit sitting between the multicycle MIPS core datapath and the Avalon-style memory bus (address/read/write/waitrequest/byteenable). It accepts one core request at a time and performs byte, halfword, word (and, for DATA_W=64, doubleword) accesses with lane steering, byte-enable generation and sign/zero extension. It also detects misaligned accesses and bus timeouts, and reports both on a response channel.

## Interface
- ADDR_W, 32: byte-address width.
- DATA_W, 32: bus data width; 32 or 64. BYTES = DATA_W/8, OFS_W = log2(BYTES).
- TIMEOUT_CYCLES, 256: maximum consecutive waitrequest-high cycles per access; 0 disables the timeout.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_signed  in  1  loads only: sign-extend when 1, zero-extend when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  2  00 = ok, 01 = misaligned or illegal size, 10 = timeout.
- address  out  ADDR_W  bus address, low OFS_W bits forced to 0.
- read, write  out  1  bus strobes.
- writedata  out  DATA_W  lane-steered store data.
- byteenable  out  BYTES  active lanes.
- waitrequest  in  1  slave stall.
- readdata  in  DATA_W  bus read data.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. When req_valid is high at a rising edge, all request fields are captured. Let ofs = req_addr[OFS_W-1:0] and n = 1<<req_size.
  - The request is illegal if req_size > OFS_W or ofs mod n != 0.
  - Illegal request: go to RESP with err=01. No bus strobe is ever asserted.
  - Legal request: go to BUS. The registered outputs become: address = {req_addr[ADDR_W-1:OFS_W], 0}; byteenable = ((1<<n)-1) << ofs; writedata = req_wdata << 8*ofs, with bytes outside the enabled lanes driven 0; read = !req_write; write = req_write.
- BUS: address, byteenable, writedata and the strobes are held stable while waitrequest=1.
  - On a cycle with waitrequest=0, the transfer completes and the unit goes to RESP with err=00.
  - For a load, it captures readdata >> 8*ofs, truncates to n bytes and extends to DATA_W per req_signed.
- Timeout (TIMEOUT_CYCLES>0): a counter is cleared on entry to BUS and increments on each BUS cycle with waitrequest=1.
  - If waitrequest=1 while the counter = TIMEOUT_CYCLES-1, the unit drops the strobes and goes to RESP with err=10 and rdata=0.
  - waitrequest=0 in that same cycle takes priority: the access completes normally.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A request is never accepted while in RESP.
- req_signed is ignored for stores and for full-width accesses.

## Timing
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; address=0; read=0; write=0; writedata=0; byteenable=0; timeout counter=0.
- All outputs are registered; there is no combinational path from bus inputs to bus outputs.
- Legal access, accepted at edge 0: strobe high in cycle 1. With k stall cycles, resp_valid is high in cycle 2+k and req_ready returns in cycle 3+k.
- Illegal access accepted at edge 0: resp_valid in cycle 1, req_ready in cycle 2.
- Timeout: the strobe is high for exactly TIMEOUT_CYCLES cycles; resp_valid follows in the next cycle.
- Reset asserted mid-BUS: strobes drop immediately (asynchronous). No resp_valid is produced for the aborted access.
- Back-to-back requests: minimum period of 3 cycles per legal zero-wait access.

## Test plan
- DATA_W=32, signed byte load at 0x103, readdata=0x80AABBCC, no stall -> address=0x100, byteenable=1000, read high for 1 cycle, resp_rdata=0xFFFFFF80, err=00.
- Unsigned half load at 0x000, readdata=0x1234F00D -> byteenable=0011, resp_rdata=0x0000F00D.
- Half store at 0x202, wdata=0x0000BEEF, waitrequest high for 3 cycles -> writedata=0xBEEF0000, byteenable=1100, write held 4 cycles with stable outputs, resp_valid in cycle 5.
- Word load at 0x101 -> no read/write ever asserted, resp_valid in cycle 1, err=01. Also req_size=3 with DATA_W=32 -> err=01.
- TIMEOUT_CYCLES=4, waitrequest stuck high on a word load -> read high for exactly 4 cycles, then resp err=10, rdata=0. Repeat with waitrequest falling in the 4th cycle -> err=00.
- Reset pulsed low during stalled store -> write=0 and byteenable=0 immediately, req_ready=1, no resp_valid. A subsequent word load at 0x10 completes normally.
